// File: rtl/prog_sequencer_if.sv
// Host-side run handshake for prog_sequencer.
// The host (master) raises req with prog_sel and may cancel a run with abort.
// The sequencer (slave) reports busy/done/timeout and the cycle count of the run.
interface prog_sequencer_if #(
    parameter int CW = 16
) ();
    logic          req;
    logic [1:0]    prog_sel;
    logic          abort;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    modport master (
        output req,
        output prog_sel,
        output abort,
        input  busy,
        input  done,
        input  timeout,
        input  cycle_count
    );

    modport slave (
        input  req,
        input  prog_sel,
        input  abort,
        output busy,
        output done,
        output timeout,
        output cycle_count
    );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller for the 9-bit-instruction core.
// It accepts a four-phase req/done handshake, selects one of four resident
// programs, loads the PC with the program entry address, then gates core
// execution until the PC reaches the program end address or halt_in is
// decoded. Enabled cycles are counted, and a watchdog ends runaway programs.
// Optional feature macro: SINGLE_STEP_EN. When it is defined, RUN with
// step_mode=1 grants one core_en cycle per rising edge of step. When it is
// not defined, step_mode and step are ignored and RUN is free-running.
module prog_sequencer #(
    parameter int D         = 12,
    parameter int CW        = 16,
    parameter int ENTRY0    = 0,
    parameter int ENTRY1    = 100,
    parameter int ENTRY2    = 200,
    parameter int ENTRY3    = 320,
    parameter int END0      = 99,
    parameter int END1      = 199,
    parameter int END2      = 318,
    parameter int END3      = 4095,
    parameter int TIMEOUT   = 4000,
    parameter int DRAIN_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    prog_sequencer_if.slave      host,
    input  logic [D-1:0]         prog_ctr,
    input  logic                 halt_in,
    input  logic                 step_mode,
    input  logic                 step,
    output logic [D-1:0]         start_addr,
    output logic                 pc_load,
    output logic                 core_en
);

    // Entry/end lookup tables indexed directly by prog_sel.
    localparam logic [3:0][D-1:0] ENTRY_TAB = {D'(ENTRY3), D'(ENTRY2), D'(ENTRY1), D'(ENTRY0)};
    localparam logic [3:0][D-1:0] END_TAB   = {D'(END3), D'(END2), D'(END1), D'(END0)};

    // Count value seen during the last allowed run cycle.
    localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);
    localparam logic          WD_ON    = (TIMEOUT != 0);
    localparam logic [3:0]    DRAIN_LD = 4'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [D-1:0]  start_addr_reg, start_addr_next;
    logic [D-1:0]  end_addr_reg, end_addr_next;
    logic [CW-1:0] cycle_count_reg, cycle_count_next;
    logic          timeout_reg, timeout_next;
    logic [3:0]    drain_cnt_reg, drain_cnt_next;
    logic          pc_load_reg, core_en_reg, busy_reg, done_reg;
    logic          core_en_next;
    logic          step_ok;
    logic          finish;
    logic          wd_hit;

`ifdef SINGLE_STEP_EN
    logic step_q_reg;

    // Registered copy of step for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q_reg <= 1'b0;
        end else begin
            step_q_reg <= step;
        end
    end

    assign step_ok = !step_mode || (step && !step_q_reg);
`else
    logic unused_step;
    assign unused_step = step_mode ^ step;
    assign step_ok     = 1'b1;
`endif

    assign finish = halt_in || (prog_ctr >= end_addr_reg);
    assign wd_hit = WD_ON && (cycle_count_reg == WD_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and next values of the run bookkeeping registers.
    always_comb begin
        state_next       = state_reg;
        start_addr_next  = start_addr_reg;
        end_addr_next    = end_addr_reg;
        cycle_count_next = cycle_count_reg;
        timeout_next     = timeout_reg;
        drain_cnt_next   = drain_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (host.req) begin
                    start_addr_next  = ENTRY_TAB[host.prog_sel];
                    end_addr_next    = END_TAB[host.prog_sel];
                    cycle_count_next = '0;
                    timeout_next     = 1'b0;
                    state_next       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (host.abort) begin
                    timeout_next = 1'b0;
                    state_next   = S_IDLE;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Every enabled cycle counts, including a finishing or aborted one.
                if (core_en_reg && (cycle_count_reg != '1)) begin
                    cycle_count_next = cycle_count_reg + 1'b1;
                end
                if (host.abort) begin
                    timeout_next = 1'b0;
                    state_next   = S_IDLE;
                end else if (core_en_reg) begin
                    if (finish) begin
                        drain_cnt_next = DRAIN_LD;
                        state_next     = S_DRAIN;
                    end else if (wd_hit) begin
                        timeout_next = 1'b1;
                        state_next   = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (host.abort) begin
                    timeout_next = 1'b0;
                    state_next   = S_IDLE;
                end else if (drain_cnt_reg == 4'd0) begin
                    state_next = S_DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 4'd1;
                end
            end
            S_DONE: begin
                if (!host.req) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        core_en_next = (state_next == S_RUN) && step_ok;
    end

    // Run bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_addr_reg  <= '0;
            end_addr_reg    <= '0;
            cycle_count_reg <= '0;
            timeout_reg     <= 1'b0;
            drain_cnt_reg   <= 4'd0;
        end else begin
            start_addr_reg  <= start_addr_next;
            end_addr_reg    <= end_addr_next;
            cycle_count_reg <= cycle_count_next;
            timeout_reg     <= timeout_next;
            drain_cnt_reg   <= drain_cnt_next;
        end
    end

    // Moore outputs registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_load_reg <= 1'b0;
            core_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            pc_load_reg <= (state_next == S_LOAD);
            core_en_reg <= core_en_next;
            busy_reg    <= (state_next == S_LOAD) || (state_next == S_RUN) ||
                           (state_next == S_DRAIN);
            done_reg    <= (state_next == S_DONE);
        end
    end

    assign start_addr       = start_addr_reg;
    assign pc_load          = pc_load_reg;
    assign core_en          = core_en_reg;
    assign host.busy        = busy_reg;
    assign host.done        = done_reg;
    assign host.timeout     = timeout_reg;
    assign host.cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_prog_sequencer.sv
// Testbench for prog_sequencer: directed and randomized runs checked against
// an outcome model computed from the program table, halt/abort points and
// the watchdog limit.
module tb_prog_sequencer;

    localparam int D         = 12;
    localparam int CW        = 16;
    localparam int TB_TIMEOUT = 120;
    localparam int DRAIN_CYC = 2;

    logic          clk;
    logic          reset;
    logic [D-1:0]  prog_ctr;
    logic          halt_in;
    logic          step_mode;
    logic          step;
    logic [D-1:0]  start_addr;
    logic          pc_load;
    logic          core_en;

    prog_sequencer_if #(.CW(CW)) ifc ();

    prog_sequencer #(
        .D(D), .CW(CW), .TIMEOUT(TB_TIMEOUT), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (ifc),
        .prog_ctr   (prog_ctr),
        .halt_in    (halt_in),
        .step_mode  (step_mode),
        .step       (step),
        .start_addr (start_addr),
        .pc_load    (pc_load),
        .core_en    (core_en)
    );

    int errors = 0;
    int checks = 0;
    int entry_t [4] = '{0, 100, 200, 320};
    int end_t   [4] = '{99, 199, 318, 4095};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run. halt_k/abort_k give the 0-based RUN cycle in which
    // halt_in/abort is raised (-1 = never). step_noise toggles step inputs
    // that the default build must ignore.
    task automatic run_case(input int sel, input int halt_k, input int abort_k, input bit step_noise);
        int start, f, w, a, term, outcome;
        start = entry_t[sel];
        f = end_t[sel] - start;
        if (halt_k >= 0 && halt_k < f) f = halt_k;
        w = TB_TIMEOUT - 1;
        a = (abort_k < 0) ? 1000000 : abort_k;
        if (a <= f && a <= w) begin
            outcome = 0; term = a;
        end else if (f <= w) begin
            outcome = 1; term = f;
        end else begin
            outcome = 2; term = w;
        end

        ifc.req = 1'b1;
        ifc.prog_sel = 2'(sel);
        tick();
        check("load_pc_load", 32'(pc_load), 1);
        check("load_start_addr", 32'(start_addr), start);
        check("load_core_en", 32'(core_en), 0);
        check("load_busy", 32'(ifc.busy), 1);
        check("load_cycle_count", 32'(ifc.cycle_count), 0);
        check("load_timeout", 32'(ifc.timeout), 0);
        ifc.prog_sel = 2'($urandom);
        prog_ctr = 12'($urandom);
        tick();
        for (int k = 0; k <= term; k++) begin
            check("run_core_en", 32'(core_en), 1);
            check("run_cycle_count", 32'(ifc.cycle_count), k);
            prog_ctr = 12'(start + k);
            halt_in = (k == halt_k);
            ifc.abort = (k == abort_k);
            if (k == abort_k) ifc.req = 1'b0;
            if (step_noise) begin
                step_mode = 1'($urandom);
                step = 1'($urandom);
            end
            tick();
        end
        halt_in = 1'b0;
        ifc.abort = 1'b0;
        step_mode = 1'b0;
        step = 1'b0;

        case (outcome)
            0: begin
                check("abort_busy", 32'(ifc.busy), 0);
                check("abort_core_en", 32'(core_en), 0);
                check("abort_done", 32'(ifc.done), 0);
                check("abort_cycle_count", 32'(ifc.cycle_count), term + 1);
                check("abort_timeout", 32'(ifc.timeout), 0);
                tick();
                check("abort_idle_done", 32'(ifc.done), 0);
                check("abort_idle_busy", 32'(ifc.busy), 0);
            end
            1: begin
                for (int d = 0; d < DRAIN_CYC; d++) begin
                    check("drain_busy", 32'(ifc.busy), 1);
                    check("drain_core_en", 32'(core_en), 0);
                    check("drain_done", 32'(ifc.done), 0);
                    tick();
                end
                check("fin_done", 32'(ifc.done), 1);
                check("fin_busy", 32'(ifc.busy), 0);
                check("fin_cycle_count", 32'(ifc.cycle_count), term + 1);
                check("fin_timeout", 32'(ifc.timeout), 0);
                tick();
                check("fin_done_hold", 32'(ifc.done), 1);
                ifc.req = 1'b0;
                tick();
                check("fin_idle_done", 32'(ifc.done), 0);
                check("fin_idle_count", 32'(ifc.cycle_count), term + 1);
            end
            default: begin
                check("wd_done", 32'(ifc.done), 1);
                check("wd_timeout", 32'(ifc.timeout), 1);
                check("wd_busy", 32'(ifc.busy), 0);
                check("wd_core_en", 32'(core_en), 0);
                check("wd_cycle_count", 32'(ifc.cycle_count), TB_TIMEOUT);
                ifc.req = 1'b0;
                tick();
                check("wd_idle_done", 32'(ifc.done), 0);
                check("wd_idle_timeout", 32'(ifc.timeout), 1);
            end
        endcase
        $display("run sel=%0d halt_k=%0d abort_k=%0d outcome=%0d cycles=%0d", sel, halt_k, abort_k, outcome, term + 1);
    endtask

    initial begin
        reset = 1'b0;
        ifc.req = 1'b0;
        ifc.prog_sel = 2'd0;
        ifc.abort = 1'b0;
        prog_ctr = '0;
        halt_in = 1'b0;
        step_mode = 1'b0;
        step = 1'b0;
        #2;
        check("rst_busy", 32'(ifc.busy), 0);
        check("rst_done", 32'(ifc.done), 0);
        check("rst_pc_load", 32'(pc_load), 0);
        check("rst_core_en", 32'(core_en), 0);
        check("rst_timeout", 32'(ifc.timeout), 0);
        check("rst_cycle_count", 32'(ifc.cycle_count), 0);
        check("rst_start_addr", 32'(start_addr), 0);
        #18 reset = 1'b1;
        tick();

        // Directed runs: full program, abort, program 2, watchdog boundary.
        run_case(1, -1, -1, 1'b0);
        run_case(1, -1, 4, 1'b0);
        run_case(2, -1, -1, 1'b0);
        run_case(3, -1, -1, 1'b0);
        run_case(3, TB_TIMEOUT - 1, -1, 1'b0);
        run_case(3, TB_TIMEOUT, -1, 1'b0);
        run_case(0, 10, 10, 1'b0);
        run_case(0, 0, -1, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            int sel, hk, ak;
            sel = int'($urandom_range(0, 3));
            hk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 130)) : -1;
            ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 130)) : -1;
            run_case(sel, hk, ak, 1'b0);
        end

`ifndef SINGLE_STEP_EN
        run_case(0, -1, -1, 1'b1);
`else
        begin
            int en_cnt;
            en_cnt = 0;
            step_mode = 1'b1;
            ifc.req = 1'b1;
            ifc.prog_sel = 2'd0;
            prog_ctr = '0;
            tick();
            check("ss_load", 32'(pc_load), 1);
            tick();
            check("ss_idle_core_en", 32'(core_en), 0);
            for (int p = 0; p < 3; p++) begin
                step = 1'b1;
                tick();
                en_cnt += int'(core_en);
                step = 1'b0;
                repeat (3) begin
                    tick();
                    en_cnt += int'(core_en);
                end
            end
            check("ss_three_pulses", 32'(en_cnt), 3);
            check("ss_three_count", 32'(ifc.cycle_count), 3);
            step = 1'b1;
            repeat (5) begin
                tick();
                en_cnt += int'(core_en);
            end
            step = 1'b0;
            repeat (2) begin
                tick();
                en_cnt += int'(core_en);
            end
            check("ss_held_pulses", 32'(en_cnt), 4);
            check("ss_held_count", 32'(ifc.cycle_count), 4);
            ifc.abort = 1'b1;
            ifc.req = 1'b0;
            tick();
            ifc.abort = 1'b0;
            step_mode = 1'b0;
            check("ss_abort_busy", 32'(ifc.busy), 0);
            $display("single-step run pulses=%0d", en_cnt);
        end
`endif

        // Reset in the middle of a run, then release with req held high.
        ifc.req = 1'b1;
        ifc.prog_sel = 2'd1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            prog_ctr = 12'(100 + k);
            tick();
        end
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(ifc.busy), 0);
        check("mid_rst_core_en", 32'(core_en), 0);
        check("mid_rst_pc_load", 32'(pc_load), 0);
        check("mid_rst_done", 32'(ifc.done), 0);
        check("mid_rst_cycle_count", 32'(ifc.cycle_count), 0);
        check("mid_rst_start_addr", 32'(start_addr), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rel_pc_load", 32'(pc_load), 1);
        check("rel_start_addr", 32'(start_addr), 100);
        ifc.abort = 1'b1;
        ifc.req = 1'b0;
        tick();
        ifc.abort = 1'b0;
        check("load_abort_busy", 32'(ifc.busy), 0);
        check("load_abort_core_en", 32'(core_en), 0);
        check("load_abort_count", 32'(ifc.cycle_count), 0);
        $display("reset/abort-in-load sequence complete");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
